// File: rtl/supercar_trail_pwm.sv
// Afterglow stage for the Supercar LED chain: per-LED brightness that snaps to
// full when lit, decays on each step once dark, and drives a registered PWM output.
module supercar_trail_pwm #(
    parameter int unsigned N_BIT      = 6,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned DECAY_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [N_BIT-1:0] pin,
    output logic [N_BIT-1:0] led,
    output logic             pwm_wrap
);

    localparam int unsigned MAX = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(MAX);
    localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'(MAX - 1);
    // A decay of MAX or more always lands on zero; keep the subtrahend in range otherwise.
    localparam bit DECAY_KILLS = (DECAY_STEP >= MAX);
    localparam logic [PWM_BITS-1:0] DECAY = PWM_BITS'(DECAY_KILLS ? 0 : DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [PWM_BITS-1:0] level      [N_BIT];
    logic [PWM_BITS-1:0] level_next [N_BIT];
    logic [N_BIT-1:0]    led_next;

    // Free-running period counter: 0 .. MAX-1.
    always_comb begin
        pwm_cnt_next = pwm_cnt + PWM_BITS'(1);
        if (pwm_cnt == CNT_LAST) begin
            pwm_cnt_next = '0;
        end
    end

    // Level update on step: lit channels jump to full, dark ones decay saturating at 0.
    always_comb begin
        for (int unsigned i = 0; i < N_BIT; i++) begin
            level_next[i] = level[i];
            if (step) begin
                if (pin[i]) begin
                    level_next[i] = LEVEL_MAX;
                end else if (DECAY_KILLS || (level[i] <= DECAY)) begin
                    level_next[i] = '0;
                end else begin
                    level_next[i] = level[i] - DECAY;
                end
            end
        end
    end

    // PWM compare against the current (pre-edge) counter and level.
    always_comb begin
        led_next = '0;
        for (int unsigned i = 0; i < N_BIT; i++) begin
            led_next[i] = (pwm_cnt < level[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt  <= '0;
            led      <= '0;
            pwm_wrap <= 1'b0;
            for (int unsigned i = 0; i < N_BIT; i++) begin
                level[i] <= '0;
            end
        end else begin
            pwm_cnt  <= pwm_cnt_next;
            led      <= led_next;
            pwm_wrap <= (pwm_cnt == '0);
            for (int unsigned i = 0; i < N_BIT; i++) begin
                level[i] <= level_next[i];
            end
        end
    end

endmodule

// File: tb/tb_supercar_trail_pwm.sv
// Bench for supercar_trail_pwm: three instances (decay 4, 0, 20) checked every
// cycle against an integer reference model, plus duty-window vectors and reset sequences.
module tb_supercar_trail_pwm;

    localparam int MAXV = 15;
    localparam int NB   = 6;

    logic          clk;
    logic          rst;
    logic          step;
    logic [NB-1:0] pin;
    logic [NB-1:0] led_v [3];
    logic [2:0]    wrap_v;

    int checks;
    int errors;

    supercar_trail_pwm #(.N_BIT(NB), .PWM_BITS(4), .DECAY_STEP(4)) dut_a (
        .clk(clk), .rst(rst), .step(step), .pin(pin), .led(led_v[0]), .pwm_wrap(wrap_v[0])
    );
    supercar_trail_pwm #(.N_BIT(NB), .PWM_BITS(4), .DECAY_STEP(0)) dut_b (
        .clk(clk), .rst(rst), .step(step), .pin(pin), .led(led_v[1]), .pwm_wrap(wrap_v[1])
    );
    supercar_trail_pwm #(.N_BIT(NB), .PWM_BITS(4), .DECAY_STEP(20)) dut_c (
        .clk(clk), .rst(rst), .step(step), .pin(pin), .led(led_v[2]), .pwm_wrap(wrap_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int decay_of(int d);
        case (d)
            0:       return 4;
            1:       return 0;
            default: return 20;
        endcase
    endfunction

    // Reference model: integer brightness, period phase = cycles since reset mod MAX.
    int          lvl [3][NB];
    int          since_rst;
    logic [NB-1:0] eled [3];
    logic        ewrap;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            armed     = 1'b1;
            since_rst = 0;
            ewrap     = 1'b0;
            for (int d = 0; d < 3; d++) begin
                eled[d] = '0;
                for (int i = 0; i < NB; i++) lvl[d][i] = 0;
            end
        end else begin
            ewrap = ((since_rst % MAXV) == 0);
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < NB; i++) begin
                    eled[d][i] = ((since_rst % MAXV) < lvl[d][i]);
                    if (step) begin
                        if (pin[i]) lvl[d][i] = MAXV;
                        else        lvl[d][i] = (lvl[d][i] > decay_of(d)) ? lvl[d][i] - decay_of(d) : 0;
                    end
                end
            end
            since_rst++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: advance to the next falling edge and compare all instances to the model.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("model_led[%0d]", d), 32'(led_v[d]), 32'(eled[d]));
                chk($sformatf("model_wrap[%0d]", d), 32'(wrap_v[d]), 32'(ewrap));
            end
        end
    endtask

    typedef struct {
        logic [NB-1:0] pin;
        int            a0;
        int            a1;
        int            a2;
        int            b0;
        int            c0;
    } vec_t;

    vec_t tbl [9];
    int   cnt [5];

    initial begin
        // pin stepped in, then high-count per 15-cycle window: dut_a LED0/1/2, dut_b LED0, dut_c LED0
        tbl[0] = '{6'b000001, 15,  0,  0, 15, 15};
        tbl[1] = '{6'b000000, 11,  0,  0, 15,  0};
        tbl[2] = '{6'b000000,  7,  0,  0, 15,  0};
        tbl[3] = '{6'b000000,  3,  0,  0, 15,  0};
        tbl[4] = '{6'b000000,  0,  0,  0, 15,  0};
        tbl[5] = '{6'b000000,  0,  0,  0, 15,  0};
        tbl[6] = '{6'b000001, 15,  0,  0, 15, 15};
        tbl[7] = '{6'b000010, 11, 15,  0, 15,  0};
        tbl[8] = '{6'b000100,  7, 11, 15, 15,  0};

        checks = 0;
        errors = 0;
        rst  = 1'b0;
        step = 1'b1;
        pin  = 6'b111111;

        // Reset held with step active: everything stays dark.
        for (int j = 0; j < 3; j++) begin
            cycle();
            for (int d = 0; d < 3; d++) begin
                chk("reset_led", 32'(led_v[d]), 32'd0);
                chk("reset_wrap", 32'(wrap_v[d]), 32'd0);
            end
        end

        // Released, idle: LEDs dark, wrap on the first edge and every 15 after.
        rst  = 1'b1;
        step = 1'b0;
        pin  = '0;
        for (int j = 1; j <= 30; j++) begin
            cycle();
            chk("idle_led", 32'(led_v[0]), 32'd0);
            chk("idle_wrap", 32'(wrap_v[0]), 32'(((j - 1) % MAXV) == 0));
        end

        // Duty windows: one step, then count highs over the next 15 cycles.
        for (int v = 0; v < 9; v++) begin
            step = 1'b1;
            pin  = tbl[v].pin;
            cycle();
            step = 1'b0;
            pin  = '0;
            for (int k = 0; k < 5; k++) cnt[k] = 0;
            for (int s = 0; s < MAXV; s++) begin
                cycle();
                cnt[0] += int'(led_v[0][0]);
                cnt[1] += int'(led_v[0][1]);
                cnt[2] += int'(led_v[0][2]);
                cnt[3] += int'(led_v[1][0]);
                cnt[4] += int'(led_v[2][0]);
            end
            chk($sformatf("duty_a0 v%0d", v), 32'(cnt[0]), 32'(tbl[v].a0));
            chk($sformatf("duty_a1 v%0d", v), 32'(cnt[1]), 32'(tbl[v].a1));
            chk($sformatf("duty_a2 v%0d", v), 32'(cnt[2]), 32'(tbl[v].a2));
            chk($sformatf("duty_b0 v%0d", v), 32'(cnt[3]), 32'(tbl[v].b0));
            chk($sformatf("duty_c0 v%0d", v), 32'(cnt[4]), 32'(tbl[v].c0));
        end

        // Mid-period reset with trail levels live.
        repeat (5) cycle();
        rst = 1'b0;
        cycle();
        for (int d = 0; d < 3; d++) begin
            chk("midrst_led", 32'(led_v[d]), 32'd0);
            chk("midrst_wrap", 32'(wrap_v[d]), 32'd0);
        end
        rst = 1'b1;
        cycle();
        chk("midrst_first_wrap", 32'(wrap_v[0]), 32'd1);
        chk("midrst_led_after", 32'(led_v[0]), 32'd0);
        for (int j = 1; j <= MAXV; j++) begin
            cycle();
            chk("midrst_wrap_period", 32'(wrap_v[0]), 32'(j == MAXV));
        end

        // Randomized traffic against the model, with occasional resets.
        for (int j = 0; j < 3000; j++) begin
            rst  = ($urandom_range(0, 99) != 0);
            step = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) pin = NB'(1) << $urandom_range(0, NB - 1);
            else                           pin = NB'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/supercar_trail_pwm.md
Name: supercar_trail_pwm

Overview:
Downstream stage of the bouncing shift register in the Supercar LED chain. Consumes the one-hot parallel pattern and the same step enable that advances the shifter. Keeps a per-LED brightness level that jumps to full when the LED is lit and decays on each step after it goes dark, producing the comet "afterglow" trail. Drives each physical LED with a registered PWM output proportional to its level.

Parameters:
N_BIT, 6, number of LEDs; must match the shifter's N_BIT.
PWM_BITS, 4, level width; MAX = 2^PWM_BITS-1 (15 by default); legal range is 2 or more.
DECAY_STEP, 4, amount subtracted from a dark LED's level on each step; 0 disables decay; a value of MAX or more extinguishes the LED in one step.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
step  input  1  one-cycle advance strobe, the same signal that drives the shifter's en.
pin  input  N_BIT  parallel pattern from the shifter's pout; bit i lights LED i.
led  output  N_BIT  registered PWM drive, one bit per LED.
pwm_wrap  output  1  registered one-cycle pulse marking the start of each PWM period.

Behaviour:
- Reset (rst=0 at a rising edge): all level[i]=0, pwm_cnt=0, led=0, pwm_wrap=0. rst overrides step. Reset mid-period or mid-decay discards all state.
- PWM counter: free-running while rst=1. Counts 0, 1, …, MAX-1 and wraps to 0. The period is MAX clock cycles (15 by default). The counter is independent of step.
- Level update, only on edges where step=1:
  - If pin[i]=1, level[i] becomes MAX.
  - Otherwise level[i] becomes level[i]-DECAY_STEP, saturating at 0. There is no underflow or wrap.
  - All N_BIT channels update in parallel on the same edge.
- Without step, levels hold. pin is ignored when step=0.
- LED output: at every edge with rst=1, led[i] is loaded with (pwm_cnt < level[i]). The compare uses the pre-edge register values of pwm_cnt and level.
  - With a constant level, each led[i] is high for exactly level[i] cycles out of every MAX consecutive cycles.
  - level=MAX gives a constant 1; level=0 gives a constant 0.
- Latency:
  - step sampled at edge k updates level at edge k.
  - The new level first affects led at edge k+1.
- pwm_wrap: loaded with (pwm_cnt==0) at each edge. It is therefore high exactly in the cycle where led shows the slot-0 compare. After reset release it pulses every MAX cycles; the first pulse comes 1 cycle after the first edge with rst=1.
- Simultaneous step and pwm wrap: no interaction. A level change takes effect mid-period, and partial-period duty is allowed.
- pin with several bits set (e.g. the shifter is seeded with multiple ones): each set bit independently forces MAX. No one-hot check is made.
- pin=0 with step: all channels decay. This is the legal "all dark" fade.
- Constraint: widths derive from the parameters only. pwm_cnt and level are PWM_BITS wide, and the compare is unsigned.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with step=1 and pin=6'b111111. Required: led=0 and pwm_wrap=0 throughout. After rst=1 with step=0, led stays 0 and pwm_wrap pulses every 15 cycles.
- Full-on: single step with pin=6'b000001, then step=0. Required: from edge k+1, led[0]=1 on every cycle; led[5:1]=0.
- Decay sequence: after the full-on case, issue 4 steps each separated by 15 idle cycles, with pin=0. Required: LED0 measured high-count per 15-cycle window is 11, 7, 3, 0; LED0 stays 0 thereafter.
- Bounce trail: drive pin 000001→000010→000100 with one step each, 15 cycles apart. Required: per-window duty on LED2/LED1/LED0 is 15/11/7.
- Parameter edges: with DECAY_STEP=0, levels hold at 15 indefinitely. With DECAY_STEP=20, a single dark step drops 15 to 0.
- Reset mid-operation: with levels at 15/11/7, assert rst=0 for 1 cycle mid-period. Required: next cycle led=0 and pwm_wrap=0. pwm_cnt restarts at 0, so pwm_wrap comes exactly 1 cycle after the first edge with rst=1.
